// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        KP_ST_SCAN     = 2'd0,
        KP_ST_DEBOUNCE = 2'd1,
        KP_ST_HELD     = 2'd2,
        KP_ST_RELEASE  = 2'd3
    } kp_state_t;

    localparam int SCAN_DIV_DEF   = 1000;
    localparam int DEB_CYCLES_DEF = 20000;

    // Active-low one-hot column strobe for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Lowest-index row pulled low; only meaningful when some bit is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd3;
        if (!r[0])      idx = 2'd0;
        else if (!r[1]) idx = 2'd1;
        else if (!r[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix pins plus decoded key outputs.
interface keypad_scan_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_val;
    logic       key_down;
    logic       key_strobe;

    modport master (input row_n, output col_n, key_val, key_down, key_strobe);
    modport slave  (output row_n, input col_n, key_val, key_down, key_strobe);
endinterface

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchroniser, resets to all-ones so idle pulled-up inputs read inactive.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column strobe rotation, press/release debounce, key latch and strobe.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV   = SCAN_DIV_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input logic           clk,
    input logic           rst,
    keypad_scan_if.master bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEB_CYCLES) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEB_CYCLES - 1);

    kp_state_t     state;
    logic [DW-1:0] dwell;
    logic [BW-1:0] deb;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [1:0]    col_next;
    logic [3:0]    row_s;
    logic          row_up;

    sync2 #(.W(4)) u_sync (.clk(clk), .rst(rst), .d(bus.row_n), .q(row_s));

    assign col_next = col_idx + 2'd1;
    assign row_up   = row_s[row_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= KP_ST_SCAN;
            dwell          <= '0;
            deb            <= '0;
            col_idx        <= 2'd0;
            row_idx        <= 2'd0;
            bus.col_n      <= 4'b1110;
            bus.key_val    <= 4'h0;
            bus.key_down   <= 1'b0;
            bus.key_strobe <= 1'b0;
        end else begin
            bus.key_strobe <= 1'b0;
            case (state)
                KP_ST_SCAN: begin
                    // Only the last dwell cycle samples, giving the synchroniser time to settle.
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (row_s != 4'hF) begin
                            row_idx <= lowest_low(row_s);
                            deb     <= '0;
                            state   <= KP_ST_DEBOUNCE;
                        end else begin
                            col_idx   <= col_next;
                            bus.col_n <= col_drive(col_next);
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                KP_ST_DEBOUNCE: begin
                    if (row_up) begin
                        state     <= KP_ST_SCAN;
                        dwell     <= '0;
                        col_idx   <= col_next;
                        bus.col_n <= col_drive(col_next);
                    end else if (deb == DEB_LAST) begin
                        state          <= KP_ST_HELD;
                        bus.key_val    <= {row_idx, col_idx};
                        bus.key_down   <= 1'b1;
                        bus.key_strobe <= 1'b1;
                    end else begin
                        deb <= deb + 1'b1;
                    end
                end
                KP_ST_HELD: begin
                    if (row_up) begin
                        state <= KP_ST_RELEASE;
                        deb   <= '0;
                    end
                end
                KP_ST_RELEASE: begin
                    // A release that bounces back is the same press, not a new one.
                    if (!row_up) begin
                        state <= KP_ST_HELD;
                        deb   <= '0;
                    end else if (deb == DEB_LAST) begin
                        state        <= KP_ST_SCAN;
                        dwell        <= '0;
                        bus.key_down <= 1'b0;
                        col_idx      <= col_next;
                        bus.col_n    <= col_drive(col_next);
                    end else begin
                        deb <= deb + 1'b1;
                    end
                end
                default: state <= KP_ST_SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: matrix keypad model, strobe scoreboard, directed scenarios.
module tb_keypad_scan;
    logic        clk;
    logic        rst;
    logic [15:0] keys;   // keys[r*4+c] pressed
    logic [3:0]  rows;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_strobe = 0;
    logic        prev_strobe = 1'b0;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_val;
    int          snap;

    keypad_scan_if bus();

    keypad_scan #(.SCAN_DIV(4), .DEB_CYCLES(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key pulls its row low while its column is driven.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !bus.col_n[c]) rows[r] = 1'b0;
    end
    assign bus.row_n = rows;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_down(input logic v, input int bound, input string tag);
        for (int i = 0; i < bound && bus.key_down !== v; i++) step(1);
        chk(tag, bus.key_down, v);
    endtask

    // Returns on the negedge right after the column switches to target.
    task automatic wait_col(input logic [3:0] target, input string tag);
        int i;
        for (i = 0; i < 40 && bus.col_n === target; i++) step(1);
        for (i = 0; i < 40 && bus.col_n !== target; i++) step(1);
        chk(tag, bus.col_n, target);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_strobe <= 1'b0;
        end else begin
            if (bus.key_strobe) begin
                n_strobe++;
                chk("strobe_run", prev_strobe, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("unexp_strobe", exp_q.size(), 1);
                end else begin
                    exp_val = exp_q.pop_front();
                    chk("sb_key_val", bus.key_val, exp_val);
                    chk("sb_key_down", bus.key_down, 1'b1);
                end
            end
            prev_strobe <= bus.key_strobe;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        keys = 16'h0;
        step(2);
        chk("rst_col", bus.col_n, 4'b1110);
        chk("rst_val", bus.key_val, 4'h0);
        chk("rst_down", bus.key_down, 1'b0);
        chk("rst_strobe", bus.key_strobe, 1'b0);
        rst = 1'b0;

        // Idle rotation: four cycles per column.
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] e;
            step(1);
            e = ~(4'b0001 << ((k / 4) % 4));
            chk("idle_col", bus.col_n, e);
        end
        chk("idle_strobes", n_strobe, 0);

        // Press row1/col2 and hold.
        snap = n_strobe;
        keys[6] = 1'b1;
        exp_q.push_back(4'h6);
        step(40);
        chk("press_strobes", n_strobe - snap, 1);
        chk("press_val", bus.key_val, 4'h6);
        chk("press_down", bus.key_down, 1'b1);
        chk("press_frozen", bus.col_n, 4'b1011);
        keys = 16'h0;
        wait_down(1'b0, 20, "release_down");
        chk("release_next_col", bus.col_n, 4'b0111);

        // Bounce: row2/col0 low three cycles around the sample.
        wait_col(4'b1110, "bounce_align");
        keys[8] = 1'b1;
        step(3);
        keys = 16'h0;
        step(2);
        chk("bounce_frozen", bus.col_n, 4'b1110);
        step(4);
        chk("bounce_resume", bus.col_n, 4'b1101);
        chk("bounce_val", bus.key_val, 4'h6);
        chk("bounce_down", bus.key_down, 1'b0);

        // Release glitch on row3/col1.
        snap = n_strobe;
        keys[13] = 1'b1;
        exp_q.push_back(4'hD);
        wait_down(1'b1, 40, "glitch_press");
        keys = 16'h0;
        step(2);
        keys[13] = 1'b1;
        step(15);
        chk("glitch_down", bus.key_down, 1'b1);
        chk("glitch_val", bus.key_val, 4'hD);
        chk("glitch_frozen", bus.col_n, 4'b1101);
        chk("glitch_strobes", n_strobe - snap, 1);
        keys = 16'h0;
        wait_down(1'b0, 20, "glitch_release");
        chk("glitch_next_col", bus.col_n, 4'b1011);

        // Rows 1 and 3 on column 0: lowest row wins.
        keys[4]  = 1'b1;
        keys[12] = 1'b1;
        exp_q.push_back(4'h4);
        wait_down(1'b1, 40, "multi_press");
        chk("multi_val", bus.key_val, 4'h4);
        keys = 16'h0;
        wait_down(1'b0, 20, "multi_release");

        // Reset in the middle of debouncing row0/col3.
        wait_col(4'b0111, "rstdeb_align");
        keys[3] = 1'b1;
        step(6);
        chk("rstdeb_frozen", bus.col_n, 4'b0111);
        snap = n_strobe;
        rst = 1'b1;
        #1;
        chk("rstdeb_col", bus.col_n, 4'b1110);
        chk("rstdeb_val", bus.key_val, 4'h0);
        chk("rstdeb_down", bus.key_down, 1'b0);
        chk("rstdeb_strobe", bus.key_strobe, 1'b0);
        keys = 16'h0;
        step(2);
        rst = 1'b0;
        step(30);
        chk("rstdeb_no_strobe", n_strobe - snap, 0);
        chk("rstdeb_val_hold", bus.key_val, 4'h0);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
